sm_addsub_pipe: RTL and testbench

//   Parametrised, 2-stage pipelined sign-magnitude adder/subtractor with running accumulator.

---
 rtl/sm_addsub_pipe.sv | 150 +++++++++++++++
 tb/tb_sm_addsub_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude add/sub/accumulate pipe with saturation; latency 2, 1 op/cycle.
// Valid/ready on both sides: S1 stalls only when S2 holds an unconsumed result.
module sm_addsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_val
);

  localparam int MW = WIDTH - 1;
  localparam logic [MW-1:0] MAXMAG = '1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  s1_t              s1_dat;
  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] acc_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  // Datapath signals between S1 and S2
  logic [WIDTH-1:0] y_word;
  logic [MW-1:0]    x_mag;
  logic [MW-1:0]    y_mag;
  logic             x_sgn;
  logic             y_sgn;
  logic [MW:0]      mag_sum;
  logic [MW-1:0]    res_mag;
  logic             res_sgn;
  logic             res_ovf;
  logic [WIDTH-1:0] res_word;
  logic             acc_wr;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = rst_n && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;

  assign out_valid = s2_valid;
  assign acc_val   = acc_q;

  // Second operand: SUB flips B's sign, ACC reads the live accumulator so
  // back-to-back ACCs see the value written on the previous edge.
  always_comb begin
    y_word = '0;
    case (s1_dat.op)
      OP_ADD:  y_word = s1_dat.b;
      OP_SUB:  y_word = {~s1_dat.b[WIDTH-1], s1_dat.b[MW-1:0]};
      OP_ACC:  y_word = acc_q;
      default: y_word = '0;
    endcase
  end

  // -0 on either input is folded to +0 before the sign comparison.
  always_comb begin
    x_mag = s1_dat.a[MW-1:0];
    y_mag = y_word[MW-1:0];
    x_sgn = s1_dat.a[WIDTH-1] && (x_mag != '0);
    y_sgn = y_word[WIDTH-1] && (y_mag != '0);
  end

  always_comb begin
    mag_sum = {1'b0, x_mag} + {1'b0, y_mag};
    res_mag = '0;
    res_sgn = 1'b0;
    res_ovf = 1'b0;
    if (x_sgn == y_sgn) begin
      res_sgn = x_sgn;
      // Sum of two MW-bit magnitudes exceeds MAXMAG exactly when it carries out.
      if (mag_sum[MW]) begin
        res_mag = MAXMAG;
        res_ovf = 1'b1;
      end else begin
        res_mag = mag_sum[MW-1:0];
      end
    end else if (x_mag >= y_mag) begin
      res_mag = x_mag - y_mag;
      res_sgn = x_sgn;
    end else begin
      res_mag = y_mag - x_mag;
      res_sgn = y_sgn;
    end

    if (s1_dat.op == OP_CLR) begin
      res_mag = '0;
      res_sgn = 1'b0;
      res_ovf = 1'b0;
    end

    res_word = {res_sgn && (res_mag != '0), res_mag};
    acc_wr   = s1_adv && ((s1_dat.op == OP_ACC) || (s1_dat.op == OP_CLR));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dat   <= '0;
      s2_valid <= 1'b0;
      out_res  <= '0;
      out_ovf  <= 1'b0;
      acc_q    <= '0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_dat.op <= op_e'(in_op);
        s1_dat.a  <= in_a;
        s1_dat.b  <= in_b;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= 1'b1;
        out_res  <= res_word;
        out_ovf  <= res_ovf;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (acc_wr) begin
        acc_q <= res_word;
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: directed corner cases plus random traffic scored
// against an integer-arithmetic model of sign-magnitude add/sub/accumulate.
module tb_sm_addsub_pipe;

  localparam int W    = 8;
  localparam int MAXM = (1 << (W - 1)) - 1;
  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, ACC = 2'd2, CLR = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_ovf;
  logic [W-1:0] acc_val;

  sm_addsub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf),
    .acc_val   (acc_val)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc = 0;
  int   checks = 0;
  int   errors = 0;
  logic last_accept;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sm2int(input logic [W-1:0] v);
    int m;
    m = int'(v[W-2:0]);
    return v[W-1] ? -m : m;
  endfunction

  function automatic exp_t sat_enc(input int r);
    exp_t e;
    e.ovf = 1'b0;
    if (r > MAXM) begin
      r = MAXM;
      e.ovf = 1'b1;
    end else if (r < -MAXM) begin
      r = -MAXM;
      e.ovf = 1'b1;
    end
    e.res = (r < 0) ? {1'b1, (W-1)'(-r)} : {1'b0, (W-1)'(r)};
    return e;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    case (op)
      ADD: e = sat_enc(sm2int(a) + sm2int(b));
      SUB: e = sat_enc(sm2int(a) - sm2int(b));
      ACC: begin
        e = sat_enc(m_acc + sm2int(a));
        m_acc = sm2int(e.res);
      end
      default: begin
        e = '0;
        m_acc = 0;
      end
    endcase
    return e;
  endfunction

  // One clock: drive inputs, score any output/input handshake, then step to the next negedge.
  task automatic tick(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ordy);
    exp_t e;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    last_accept = v && in_ready;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output observed=0x%0h expected=none", out_res);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_res", out_res, e.res);
        chk("sb_ovf", out_ovf, e.ovf);
      end
    end
    if (last_accept) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, ADD, '0, '0, 1'b1);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
      tick(1'b0, ADD, '0, '0, 1'b1);
      guard++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic eo);
    tick(1'b1, op, a, b, 1'b1);
    tick(1'b0, ADD, '0, '0, 1'b1);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_res"}, out_res, er);
    chk({tag, "_ovf"}, out_ovf, eo);
    idle(1);
  endtask

  initial begin
    int sent;
    int guard;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst_n = 1'b0;
    tick(1'b0, ADD, '0, '0, 1'b0);
    tick(1'b0, ADD, '0, '0, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_res", out_res, 8'h00);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_acc_val", acc_val, 8'h00);
    chk("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Latency: accepted at edge k, visible after edge k+1.
    tick(1'b1, ADD, 8'h05, 8'h83, 1'b1);
    chk("lat_k_valid", out_valid, 1'b0);
    tick(1'b0, ADD, '0, '0, 1'b1);
    chk("lat_k1_valid", out_valid, 1'b1);
    chk("lat_res", out_res, 8'h02);
    chk("lat_ovf", out_ovf, 1'b0);
    idle(1);

    single("sub_eq_neg", SUB, 8'h85, 8'h85, 8'h00, 1'b0);
    single("add_negzero", ADD, 8'h80, 8'h80, 8'h00, 1'b0);
    single("add_pos_sat", ADD, 8'h64, 8'h32, 8'h7F, 1'b1);
    single("add_neg_sat", ADD, 8'hE4, 8'hB2, 8'hFF, 1'b1);
    single("sub_mixed", SUB, 8'h03, 8'h88, 8'h0B, 1'b0);
    single("add_neg_big", ADD, 8'h02, 8'h89, 8'h87, 1'b0);

    // Back-to-back accumulate with no stall.
    tick(1'b1, CLR, 8'h00, 8'h00, 1'b1);
    tick(1'b1, ACC, 8'h0A, 8'h55, 1'b1);
    chk("acc0_res", out_res, 8'h00);
    tick(1'b1, ACC, 8'h99, 8'h00, 1'b1);
    chk("acc1_res", out_res, 8'h0A);
    tick(1'b1, ACC, 8'h03, 8'h00, 1'b1);
    chk("acc2_res", out_res, 8'h8F);
    tick(1'b0, ADD, '0, '0, 1'b1);
    chk("acc3_res", out_res, 8'h8C);
    chk("acc3_valid", out_valid, 1'b1);
    idle(1);
    chk("acc_final", acc_val, 8'h8C);

    // Backpressure: two accepts fill the pipe, third must stall.
    tick(1'b1, ADD, 8'h01, 8'h02, 1'b0);
    tick(1'b1, ADD, 8'h02, 8'h04, 1'b0);
    chk("bp_in_ready_0", in_ready, 1'b0);
    tick(1'b1, ADD, 8'h03, 8'h06, 1'b0);
    chk("bp_stall_accept", last_accept, 1'b0);
    chk("bp_in_ready_1", in_ready, 1'b0);
    chk("bp_hold_res", out_res, 8'h03);
    sent = 2;
    guard = 0;
    while (sent < 4 && guard < 20) begin
      a = W'(sent + 1);
      b = W'(2 * (sent + 1));
      tick(1'b1, ADD, a, b, 1'b1);
      if (last_accept) sent++;
      guard++;
    end
    chk("bp_all_sent", sent, 4);
    drain("bp_drained");

    // Reset with both stages full and a non-zero accumulator.
    tick(1'b1, CLR, 8'h00, 8'h00, 1'b1);
    tick(1'b1, ACC, 8'h20, 8'h00, 1'b1);
    idle(2);
    chk("pre_rst_acc", acc_val, 8'h20);
    tick(1'b1, ADD, 8'h01, 8'h01, 1'b0);
    tick(1'b1, ADD, 8'h02, 8'h02, 1'b0);
    chk("pre_rst_full", out_valid, 1'b1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    tick(1'b0, ADD, '0, '0, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_acc", acc_val, 8'h00);
    exp_q.delete();
    m_acc = 0;
    rst_n = 1'b1;
    idle(4);
    chk("post_rst_no_stale", out_valid, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    drain("rand_drained");
    chk("rand_acc", acc_val, sat_enc(m_acc).res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
